// File: rtl/spmv_row_collector.sv
// Collects per-row results from the CSR SpMV multiplier, tags them with a row index,
// buffers them in a FIFO and streams them out over valid/ready; pulses done per pass.
module spmv_row_collector #(
  parameter int DATA_W     = 64,
  parameter int NUM_ROWS   = 560,
  parameter int ROW_W      = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_zeros,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ROW_W + 2 * DATA_W;
  localparam logic [ROW_W:0] LAST_ROW = (ROW_W + 1)'(NUM_ROWS - 1);
  localparam logic [ROW_W:0] ROWS_END = (ROW_W + 1)'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [ROW_W:0] row_in, row_out;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [EW-1:0]  head;
  logic           empty, full, event_in, in_run, accept, push, pop, clear;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign event_in = in_valid | in_zeros;
  assign in_run   = (state == RUN);
  assign accept   = in_run & event_in;
  assign pop      = ~empty & out_ready;
  // a pop frees the slot at the same edge, so a full FIFO can still take the push
  assign push     = accept & (~full | pop);
  assign clear    = (state == IDLE) & start;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (event_in && row_in == LAST_ROW) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (row_out == ROWS_END && empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row_in    <= '0;
      row_out   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear)       row_in <= '0;
      else if (accept) row_in <= row_in + 1'b1;
      if (clear)       row_out <= '0;
      else if (pop)    row_out <= row_out + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && full && !pop) overflow <= 1'b1;
      else if (clear)             overflow <= 1'b0;
      if ((in_run && in_valid && in_zeros) || (!in_run && event_in)) proto_err <= 1'b1;
      else if (clear)                                                proto_err <= 1'b0;
    end
  end

  // storage carries no reset; reads are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {row_in[ROW_W-1:0],
                              in_valid ? in_data1 : {DATA_W{1'b0}},
                              in_valid ? in_data2 : {DATA_W{1'b0}}};
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = ~empty;
  assign out_row   = empty ? '0 : head[EW-1 -: ROW_W];
  assign out_data1 = empty ? '0 : head[2*DATA_W-1 -: DATA_W];
  assign out_data2 = empty ? '0 : head[DATA_W-1:0];

endmodule

// File: tb/tb_spmv_row_collector.sv
// Bench for spmv_row_collector: a short 4-row instance for latency/done timing and a
// default 560-row instance checked cycle by cycle against a queue-based reference.
module tb_spmv_row_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // short-pass instance
  logic        start_a = 0, a_iv = 0, a_iz = 0;
  logic [63:0] a_d1 = 0, a_d2 = 0;
  logic        a_out_valid, a_busy, a_done, a_overflow, a_proto_err;
  logic [9:0]  a_out_row;
  logic [63:0] a_out_data1, a_out_data2;

  // full-pass instance
  logic        start_b = 0, in_valid = 0, in_zeros = 0, out_ready = 0;
  logic [63:0] in_data1 = 0, in_data2 = 0;
  logic        b_out_valid, b_busy, b_done, b_overflow, b_proto_err;
  logic [9:0]  b_out_row;
  logic [63:0] b_out_data1, b_out_data2;

  spmv_row_collector #(.NUM_ROWS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(a_iv), .in_zeros(a_iz),
    .in_data1(a_d1), .in_data2(a_d2), .out_valid(a_out_valid), .out_ready(1'b1),
    .out_row(a_out_row), .out_data1(a_out_data1), .out_data2(a_out_data2),
    .busy(a_busy), .done(a_done), .overflow(a_overflow), .proto_err(a_proto_err));

  spmv_row_collector dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_zeros(in_zeros),
    .in_data1(in_data1), .in_data2(in_data2), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_row(b_out_row), .out_data1(b_out_data1), .out_data2(b_out_data2),
    .busy(b_busy), .done(b_done), .overflow(b_overflow), .proto_err(b_proto_err));

  int tests = 0, fails = 0;
  int done_cnt_b = 0, xfer_b = 0;

  // reference: FIFO contents as a queue plus pass bookkeeping
  logic [137:0] q[$];
  bit m_run = 0, m_ovf = 0, m_perr = 0;
  int m_in = 0;

  always @(negedge clk) if (b_done) done_cnt_b++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic iz, input logic [63:0] a,
                     input logic [63:0] b, input logic rdy);
    int sz;
    bit pop;
    in_valid = iv; in_zeros = iz; in_data1 = a; in_data2 = b; out_ready = rdy;
    #1;
    check("out_valid", b_out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_row", b_out_row, q[0][137:128]);
      check("out_data1", b_out_data1, q[0][127:64]);
      check("out_data2", b_out_data2, q[0][63:0]);
    end
    check("overflow", b_overflow, m_ovf);
    check("proto_err", b_proto_err, m_perr);
    if (b_out_valid && rdy) xfer_b++;
    sz  = q.size();
    pop = (sz != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (iv || iz) begin
      if (m_run) begin
        if (iv && iz) m_perr = 1;
        if (sz < 16 || pop) q.push_back({m_in[9:0], iv ? a : 64'd0, iv ? b : 64'd0});
        else m_ovf = 1;
        m_in++;
        if (m_in == 560) m_run = 0;
      end else m_perr = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_pass_b();
    start_b = 1;
    cyc(0, 0, 0, 0, 0);
    start_b = 0;
    m_run = 1; m_in = 0; m_ovf = 0; m_perr = 0; xfer_b = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; in_zeros = 0; out_ready = 0; start_b = 0; start_a = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    q.delete();
    m_run = 0; m_ovf = 0; m_perr = 0; m_in = 0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r1, r2;
    logic [63:0] exp_d1[4];
    logic [63:0] exp_d2[4];
    bit          is_zero[4];
    bit          seen;
    int          cnt;
    logic        iv, iz;

    // reset state
    #12;
    check("rst_out_valid", b_out_valid, 1'b0);
    check("rst_out_row", b_out_row, 10'd0);
    check("rst_out_data1", b_out_data1, 64'd0);
    check("rst_busy", b_busy, 1'b0);
    check("rst_done", b_done, 1'b0);
    check("rst_overflow", b_overflow, 1'b0);
    check("rst_proto_err", b_proto_err, 1'b0);
    check("rst_a_out_valid", a_out_valid, 1'b0);
    do_reset();

    // 4-row pass with out_ready tied high
    exp_d1 = '{64'd5, 64'd0, -64'd3, 64'd1};
    exp_d2 = '{64'd7, 64'd0, 64'd9, 64'd1};
    is_zero = '{0, 1, 0, 0};
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    check("a_busy_run", a_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a_iv = !is_zero[i]; a_iz = is_zero[i];
      a_d1 = is_zero[i] ? 64'hdead : exp_d1[i];
      a_d2 = is_zero[i] ? 64'hbeef : exp_d2[i];
      @(negedge clk);
      check("a_out_valid", a_out_valid, 1'b1);
      check("a_out_row", a_out_row, 10'(i));
      check("a_out_data1", a_out_data1, exp_d1[i]);
      check("a_out_data2", a_out_data2, exp_d2[i]);
    end
    a_iv = 0; a_iz = 0;
    @(negedge clk);
    check("a_drained", a_out_valid, 1'b0);
    check("a_done_early", a_done, 1'b0);
    @(negedge clk);
    check("a_done", a_done, 1'b1);
    @(negedge clk);
    check("a_done_once", a_done, 1'b0);
    check("a_busy_end", a_busy, 1'b0);
    check("a_proto_err", a_proto_err, 1'b0);

    // 17 events into a stalled consumer: 16 held, the 17th dropped
    start_pass_b();
    for (int i = 0; i < 17; i++) cyc(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    check("t2_overflow", b_overflow, 1'b1);
    check("t2_head_row", b_out_row, 10'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1);
    check("t2_empty", b_out_valid, 1'b0);
    do_reset();

    // full FIFO with simultaneous push and pop
    start_pass_b();
    for (int i = 0; i < 16; i++) cyc(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    cyc(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 1);
    check("t3_overflow", b_overflow, 1'b0);
    check("t3_head_row", b_out_row, 10'd1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1);
    check("t3_empty", b_out_valid, 1'b0);
    do_reset();

    // in_valid and in_zeros together
    start_pass_b();
    cyc(1, 1, 64'd2, 64'd3, 1);
    check("t4_proto_err", b_proto_err, 1'b1);
    check("t4_data1", b_out_data1, 64'd2);
    check("t4_data2", b_out_data2, 64'd3);
    cyc(1, 0, 64'd11, 64'd12, 1);
    check("t4_next_row", b_out_row, 10'd1);
    cyc(0, 0, 0, 0, 1);
    do_reset();

    // asynchronous reset with 5 rows buffered
    start_pass_b();
    for (int i = 0; i < 5; i++) cyc(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    check("t5_buffered", b_out_valid, 1'b1);
    #2 rst = 0;
    #1;
    check("t5_async_valid", b_out_valid, 1'b0);
    check("t5_async_row", b_out_row, 10'd0);
    check("t5_async_data1", b_out_data1, 64'd0);
    check("t5_async_data2", b_out_data2, 64'd0);
    check("t5_async_busy", b_busy, 1'b0);
    @(negedge clk);
    rst = 1;
    q.delete();
    m_run = 0; m_ovf = 0; m_perr = 0; m_in = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("t5_busy_after", b_busy, 1'b0);
    end
    do_reset();

    // full 560-row pass with random backpressure
    done_cnt_b = 0;
    start_pass_b();
    cnt = 0;
    while ((m_run || q.size() != 0) && cnt < 20000) begin
      iv = 0; iz = 0;
      if (m_run && q.size() < 16 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 4) == 0) iz = 1;
        else iv = 1;
      end
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      cyc(iv, iz, r1, r2, 1'($urandom_range(0, 1)));
      cnt++;
    end
    check("t6_budget", cnt < 20000, 1'b1);
    check("t6_transfers", xfer_b, 560);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (b_done) seen = 1;
    end
    check("t6_done_count", done_cnt_b, 1);
    check("t6_overflow", b_overflow, 1'b0);
    check("t6_busy_end", b_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
